// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for the program_counter register.
// It drives the next PC and issues instruction-memory reads with ready/valid.
// It tracks in-flight requests and queues returned instructions in order for
// decode. A redirect flushes the queue and discards responses that are stale.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
//
// state | meaning
// ------+------------------------------------------------------------------
// BOOT  | after reset; pc_next forced to RESET_ADDR, no requests issued
// RUN   | normal fetch / response / redirect handling
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  output logic              busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  // One counter width covers outstanding, kill and occupancy (MAX_OUT <= DEPTH).
  localparam int CNT_W = $clog2(DEPTH + 1) + 1;
  localparam int QP_W = $clog2(DEPTH);
  localparam int IP_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [IP_W-1:0] IP_LAST = IP_W'(MAX_OUT - 1);

  typedef enum logic {BOOT, RUN} state_e;

  state_e state_q;

  logic [CNT_W-1:0] out_q;
  logic [CNT_W-1:0] kill_q;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W:0] fill;

  logic [IP_W-1:0] if_wr_q;
  logic [IP_W-1:0] if_rd_q;
  logic [ADDR_W-1:0] if_pc_q [MAX_OUT];

  logic [QP_W-1:0] q_wr_q;
  logic [QP_W-1:0] q_rd_q;
  logic [DATA_W-1:0] q_data_q [DEPTH];
  logic [ADDR_W-1:0] q_pc_q [DEPTH];
  logic [DATA_W-1:0] hold_data_q;
  logic [ADDR_W-1:0] hold_pc_q;

  logic run;
  logic redir;
  logic accept;
  logic resp;
  logic push;
  logic pop;

  // The in-flight PC FIFO may have a non-power-of-two depth, so wrap explicitly.
  function automatic logic [IP_W-1:0] if_inc(input logic [IP_W-1:0] p);
    return (p == IP_LAST) ? '0 : p + IP_W'(1);
  endfunction

  assign run = (state_q == RUN);
  assign redir = run & redirect_valid;
  assign fill = {1'b0, out_q} + {1'b0, occ_q};

  // A request reserves its queue slot up front, so a response always fits.
  assign imem_req = run & ~redirect_valid & (out_q < MAX_OUT_C) & (fill < DEPTH_C);
  assign imem_addr = pc_in;
  assign accept = imem_req & imem_ready;
  assign resp = imem_rvalid & (out_q != '0);
  assign push = resp & (kill_q == '0) & ~redir;

  assign ir_valid = (occ_q != '0);
  assign pop = ir_valid & ir_ready;
  assign busy = (out_q != '0) | ir_valid;
  assign ir_data = ir_valid ? q_data_q[q_rd_q] : hold_data_q;
  assign ir_pc = ir_valid ? q_pc_q[q_rd_q] : hold_pc_q;

  // Next-PC selection: boot vector, redirect target, sequential or hold.
  always_comb begin
    pc_next = pc_in;
    if (!run) begin
      pc_next = RESET_ADDR;
    end else if (redirect_valid) begin
      pc_next = redirect_addr;
    end else if (accept) begin
      pc_next = pc_in + ADDR_W'(4);
    end
  end

  // BOOT lasts one edge so program_counter has loaded RESET_ADDR before fetching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      case (state_q)
        BOOT:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // Outstanding/kill bookkeeping and in-flight FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      kill_q  <= '0;
      if_wr_q <= '0;
      if_rd_q <= '0;
    end else begin
      out_q <= out_q + CNT_W'(accept) - CNT_W'(resp);
      if (redir) begin
        // Everything still in flight after this cycle's response is stale.
        kill_q <= out_q - CNT_W'(resp);
      end else if (resp && (kill_q != '0)) begin
        kill_q <= kill_q - CNT_W'(1);
      end
      if (accept) begin
        if_wr_q <= if_inc(if_wr_q);
      end
      if (resp) begin
        if_rd_q <= if_inc(if_rd_q);
      end
    end
  end

  // In-flight PC storage; data-only, needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if_pc_q[if_wr_q] <= pc_in;
    end
  end

  // Instruction-queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wr_q <= '0;
      q_rd_q <= '0;
      occ_q  <= '0;
    end else if (redir) begin
      q_wr_q <= '0;
      q_rd_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        q_wr_q <= q_wr_q + QP_W'(1);
      end
      if (pop) begin
        q_rd_q <= q_rd_q + QP_W'(1);
      end
      occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Instruction-queue storage; data-only, needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[q_wr_q] <= imem_rdata;
      q_pc_q[q_wr_q]   <= if_pc_q[if_rd_q];
    end
  end

  // Remember the last head shown so ir_data/ir_pc stay stable while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= '0;
      hold_pc_q   <= '0;
    end else if (ir_valid) begin
      hold_data_q <= q_data_q[q_rd_q];
      hold_pc_q   <= q_pc_q[q_rd_q];
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-instruction and decode-starvation counters, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (run && !ir_valid && !redirect_valid) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
